// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-control blocks: compare width,
// sequencer state encoding and the requester-index width helper.
package pwm_pkg;

  localparam int PWM_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } seq_state_e;

  // Index width for an n-way requester set; never narrower than one bit.
  function automatic int REQ_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched upward from the
// priority pointer; the pointer moves past the winner on each advance strobe.
module rr_arbiter
  import pwm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            req_i,
  input  logic                    advance_i,
  output logic [N-1:0]            gnt_o,
  output logic [REQ_IDX_W(N)-1:0] gnt_idx_o
);

  localparam int IW = REQ_IDX_W(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW-1:0] sel;
  logic          found;
  int            idx;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (!found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        gnt_idx_o  = sel;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Shared PWM duty controller: grants one requester at a time and ramps the
// compare value toward its target, changing it only on PWM period ticks.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int WIDTH  = PWM_WIDTH,
  parameter int NREQ   = 4,
  parameter int STEP_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ*WIDTH-1:0]      req_duty_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [STEP_W-1:0]          step_i,
  input  logic                       period_tick_i,
  output logic [WIDTH-1:0]           duty_o,
  output logic [REQ_IDX_W(NREQ)-1:0] owner_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int IDX_W = REQ_IDX_W(NREQ);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             done_q, done_d;

  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             transfer;
  logic [WIDTH-1:0] sel_duty;

  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   mag;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   move;
  logic [WIDTH-1:0] ramp_duty;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_valid_i),
    .advance_i (transfer),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign transfer = |(req_valid_i & req_ready_o);
  assign sel_duty = req_duty_i[gnt_idx*WIDTH +: WIDTH];

  // Signed distance in WIDTH+1 bits; the step is clamped to its magnitude
  // so the ramp can never overshoot or wrap past either rail.
  assign diff      = {1'b0, target_q} - {1'b0, duty_q};
  assign mag       = diff[WIDTH] ? (~diff + 1'b1) : diff;
  assign step_ext  = (WIDTH+1)'(step_i);
  assign move      = ((step_i == '0) || (step_ext >= mag)) ? mag : step_ext;
  assign ramp_duty = diff[WIDTH] ? (duty_q - move[WIDTH-1:0])
                                 : (duty_q + move[WIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      owner_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      owner_q  <= owner_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    owner_d  = owner_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          target_d = sel_duty;
          owner_d  = gnt_idx;
          if (sel_duty != duty_q) state_d = RAMP;
          else                    done_d  = 1'b1;
        end
      end
      RAMP: begin
        if (period_tick_i) begin
          duty_d = ramp_duty;
          if (ramp_duty == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grants are offered only while idle and out of reset.
  always_comb begin
    req_ready_o = gnt & {NREQ{(state_q == IDLE) && !rst}};
    busy_o      = (state_q == RAMP);
    duty_o      = duty_q;
    owner_o     = owner_q;
    done_o      = done_q;
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: reset, ramps, clamp, jump/equal
// targets and round-robin grant order, with hand-computed expectations.
module tb_pwm_duty_sequencer;

  localparam int WIDTH  = 8;
  localparam int NREQ   = 4;
  localparam int STEP_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_duty;
  logic [NREQ-1:0]       req_ready;
  logic [STEP_W-1:0]     step;
  logic                  tick;
  logic [WIDTH-1:0]      duty;
  logic [1:0]            owner;
  logic                  busy;
  logic                  done;

  int n_cmp  = 0;
  int n_fail = 0;

  pwm_duty_sequencer #(.WIDTH(WIDTH), .NREQ(NREQ), .STEP_W(STEP_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_duty_i    (req_duty),
    .req_ready_o   (req_ready),
    .step_i        (step),
    .period_tick_i (tick),
    .duty_o        (duty),
    .owner_o       (owner),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] v);
    req_duty[i*WIDTH +: WIDTH] = v;
  endtask

  logic [WIDTH-1:0] prev_t;
  logic [WIDTH-1:0] tgt;

  initial begin
    rst = 1'b1; req_valid = '0; req_duty = '0; step = '0; tick = 1'b0;
    cyc(); cyc();
    check("rst_duty",  duty, 0);
    check("rst_owner", owner, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_ready", req_ready, 0);
    rst = 1'b0;

    // Up-ramp: 0 -> 0x10 in steps of 4.
    step = 4'd4; set_req(0, 8'h10); req_valid = 4'b0001; #1;
    check("up_ready", req_ready, 4'b0001);
    cyc(); req_valid = '0;
    check("up_busy",  busy, 1);
    check("up_owner", owner, 0);
    check("up_duty0", duty, 0);
    req_valid = 4'b0010; #1;
    check("up_ready_while_busy", req_ready, 0);
    req_valid = '0;
    cyc();
    check("up_no_tick_hold", duty, 0);
    tick = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("up_duty", duty, 4 * k);
      check("up_done", done, (k == 4) ? 1 : 0);
      check("up_busy_step", busy, (k == 4) ? 0 : 1);
    end
    tick = 1'b0;
    cyc();
    check("up_done_pulse_end", done, 0);

    // Jump to 0xFF via req1, then clamped ramp down to 0x02 with step 15.
    step = 4'd0; set_req(1, 8'hFF); req_valid = 4'b0010; #1;
    check("jmpff_ready", req_ready, 4'b0010);
    cyc(); req_valid = '0;
    check("jmpff_owner", owner, 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("jmpff_duty", duty, 8'hFF);
    check("jmpff_done", done, 1);

    step = 4'd15; set_req(1, 8'h02); req_valid = 4'b0010; #1;
    check("down_ready", req_ready, 4'b0010);
    cyc(); req_valid = '0;
    tick = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      check("down_duty", duty, 255 - 15 * k);
      check("down_done", done, 0);
    end
    cyc(); tick = 1'b0;
    check("down_final", duty, 8'h02);
    check("down_final_done", done, 1);
    check("down_final_busy", busy, 0);

    // Zero via req2, then ramp 0 -> 0xFF with step 15 via req3.
    step = 4'd0; set_req(2, 8'h00); req_valid = 4'b0100; #1;
    cyc(); req_valid = '0;
    tick = 1'b1; cyc(); tick = 1'b0;
    check("zero_duty", duty, 0);
    step = 4'd15; set_req(3, 8'hFF); req_valid = 4'b1000; #1;
    check("upff_ready", req_ready, 4'b1000);
    cyc(); req_valid = '0;
    tick = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      check("upff_duty", duty, 15 * k);
    end
    cyc(); tick = 1'b0;
    check("upff_final", duty, 8'hFF);
    check("upff_done", done, 1);

    // Jump to 0xA5, then an equal-target request.
    step = 4'd0; set_req(0, 8'hA5); req_valid = 4'b0001; #1;
    check("jmp_ready", req_ready, 4'b0001);
    cyc(); req_valid = '0;
    tick = 1'b1; cyc(); tick = 1'b0;
    check("jmp_duty", duty, 8'hA5);
    check("jmp_done", done, 1);
    check("jmp_busy", busy, 0);
    set_req(1, 8'hA5); req_valid = 4'b0010; #1;
    check("eq_ready", req_ready, 4'b0010);
    cyc(); req_valid = '0;
    check("eq_done",  done, 1);
    check("eq_busy",  busy, 0);
    check("eq_owner", owner, 1);
    check("eq_duty",  duty, 8'hA5);
    cyc();
    check("eq_done_end", done, 0);
    check("eq_busy_end", busy, 0);

    // Reach 0x80, start a ramp away from it, and reset mid-ramp.
    step = 4'd0; set_req(2, 8'h80); req_valid = 4'b0100; #1;
    cyc(); req_valid = '0;
    tick = 1'b1; cyc(); tick = 1'b0;
    check("pre_rst_duty", duty, 8'h80);
    step = 4'd4; set_req(3, 8'h00); req_valid = 4'b1000; #1;
    cyc();
    check("mid_busy",  busy, 1);
    check("mid_owner", owner, 3);
    check("mid_duty",  duty, 8'h80);
    set_req(0, 8'h01); set_req(1, 8'h02); set_req(2, 8'h03); set_req(3, 8'h04);
    req_valid = 4'b1111; rst = 1'b1; #1;
    check("rst_ready_during", req_ready, 0);
    cyc(); rst = 1'b0;
    check("mid_rst_duty",  duty, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_owner", owner, 0);
    check("mid_rst_done",  done, 0);

    // Round-robin with all requesters valid; tick coincides with each transfer.
    step = 4'd0; prev_t = 8'h00;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % 4;
      tgt = 8'(g + 1);
      #1;
      check("rr_ready", req_ready, 4'b0001 << g);
      tick = 1'b1;
      cyc();
      check("rr_owner", owner, g);
      check("rr_busy", busy, 1);
      check("rr_ready_busy", req_ready, 0);
      check("rr_tick_on_xfer", duty, prev_t);
      cyc();
      tick = 1'b0;
      check("rr_duty", duty, tgt);
      check("rr_done", done, 1);
      check("rr_busy_end", busy, 0);
      prev_t = tgt;
    end
    req_valid = '0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
